dio_sdram_loader: RTL and testbench
===================================

Name: dio_sdram_loader

Overview:
- Sequences HPS file downloads (ROM image, two floppy images) into SDRAM.
- Packs the ioctl byte stream into 16-bit words and buffers them in a small FIFO.
- Writes each word only inside the SDRAM download slot granted by the address controller, and throttles HPS with ioctl_wait.
- At the end of each download, classifies floppy image size into per-drive inserted flags, which the data controller consumes.

Parameters:
- DEPTH, 4, FIFO depth in words (power of two, minimum 2).
- ROM_BASE, 21'h000000, word base address for index 0.
- DSK0_BASE, 21'h080000, word base address for index 1.
- DSK1_BASE, 21'h100000, word base address for index ≥2.

Ports:
- clk_sys  in  1  system clock.
- n_reset  in  1  synchronous active-low reset.
- ioctl_download  in  1  download in progress.
- ioctl_index  in  8  file index.
- ioctl_wr  in  1  byte strobe, single cycle.
- ioctl_addr  in  25  byte address of the strobed byte; equals total byte count once ioctl_download falls.
- ioctl_dout  in  8  byte data.
- ioctl_wait  out  1  backpressure to HPS.
- slot  in  1  download slot active (level, multi-cycle, from address controller).
- dl_cycle  out  1  loader owns SDRAM this cycle.
- sdram_addr  out  25  word address: {4'b0001, base+word_addr[20:0]}.
- sdram_din  out  16  write data.
- sdram_we  out  1  write enable.
- disk_eject  in  2  per-drive eject pulse from the data controller.
- dsk_ds  out  2  double-sided image present (bit0 internal, bit1 external).
- dsk_ss  out  2  single-sided image present.
- rom_loaded  out  1  ROM download completed since reset.

Behaviour:
- Reset (n_reset=0) clears the FIFO, byte latch and FSM to IDLE. All outputs go to 0: ioctl_wait, dl_cycle, sdram_we, sdram_addr, sdram_din, dsk_ds, dsk_ss, rom_loaded.
- Reset mid-download discards buffered words. No SDRAM write is issued in the reset cycle.
- Byte packing:
  - ioctl_wr with ioctl_addr[0]=0 latches the byte as the high byte.
  - ioctl_addr[0]=1 pushes {high, ioctl_dout} with word address ioctl_addr[21:1].
  - Base is selected by ioctl_index at push time. The sum is truncated to 21 bits.
- Backpressure: ioctl_wait is registered and equals (count ≥ DEPTH-1), so one in-flight byte pair still fits.
  - A push into a full FIFO is dropped and sets the internal overflow flag (visible only in simulation assertion).
- busy = ioctl_download || FIFO non-empty || FSM≠IDLE. dl_cycle = busy && slot (combinational).
- Write FSM:
  - IDLE: when the FIFO is non-empty, load the head into sdram_addr/sdram_din → ARMED.
  - ARMED: on the first cycle with slot=1, set sdram_we=1 → WRITE.
  - WRITE: hold sdram_we=1 while slot=1. When slot falls, sdram_we=0, pop the head → IDLE.
  - Exactly one word is written per slot. Latency from push to write is at least 2 cycles plus the slot wait.
  - If slot is already high when ARMED is entered, the write starts next cycle and the word is still held until slot falls.
- Push and pop in the same cycle: count is unchanged.
- End of download (falling edge of ioctl_download):
  - If an unpaired high byte is pending, push {high, 8'hFF} at the next word address.
  - Capture size = ioctl_addr[24:1] and the index, then go to FINISH.
  - FINISH waits until the FIFO is empty and the FSM is IDLE, then applies the result in one cycle:
    - index 0: rom_loaded←1.
    - index 1: dsk_ds[0]←(size==409600), dsk_ss[0]←(size==204800).
    - index 2: same tests on bit 1.
    - Other indices: no flag change.
- disk_eject[n] clears dsk_ds[n] and dsk_ss[n]. If an eject and a FINISH apply hit the same drive in the same cycle, eject wins.
- A new download starting during FINISH is accepted. The pending result is still applied using the captured index.

Optional Feature:
- Macro DIO_CHECKSUM_EN.
- Enabled: adds port checksum out 16.
  - Running 16-bit modular sum of every word actually written (on WRITE→IDLE).
  - Cleared on the rising edge of ioctl_download.
  - Frozen and valid once the FINISH result is applied.
- Disabled: the port and adder are absent. Behaviour is otherwise identical.

Decomposition:
- Package dio_pkg: state enum (IDLE, ARMED, WRITE), FIN flag, the three base constants, DSK_DS_WORDS=409600, DSK_SS_WORDS=204800, and the FIFO entry struct {addr[20:0], data[15:0]}.
- One sub-module: dio_word_fifo (synchronous FIFO with count, parameter DEPTH).

Test Plan:
- Index 0, 8 bytes 00..07, slot pulsing every 8 cycles → four writes at sdram_addr 25'h0200000..0200003 with data 0001, 0203, 0405, 0607. rom_loaded=1 after the drain.
- Index 1, 819200 bytes (slot every 8 cycles) → first write at 25'h0280000. dsk_ds=2'b01, dsk_ss=0.
- Index 2 with ioctl_addr ending at 409600 → dsk_ss=2'b10. Then disk_eject=2'b10 → dsk_ss=0.
- slot held low, 10 byte strobes, DEPTH=4 → ioctl_wait=1 after the 3rd word, no write issued. Raising slot drains one word per slot and ioctl_wait drops when count<3.
- Odd length: 3 bytes AA,BB,CC → writes AABB then CCFF.
- Reset asserted while ARMED → sdram_we never rises, FIFO empty, all flags 0. With DIO_CHECKSUM_EN, words 0001+0203 → checksum 0204.

Source files
------------

// File: rtl/dio_pkg.sv
// rtl/dio_pkg.sv - shared types and constants for the HPS-to-SDRAM download loader
package dio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_WRITE = 2'd2
  } wr_state_t;

  // End-of-download result waiting for the write path to drain.
  typedef struct packed {
    logic        pend;
    logic [7:0]  idx;
    logic [23:0] size;
  } fin_t;

  typedef struct packed {
    logic [20:0] addr;
    logic [15:0] data;
  } fifo_entry_t;

  localparam int          ENTRY_W       = 37;
  localparam logic [20:0] ROM_BASE_DEF  = 21'h000000;
  localparam logic [20:0] DSK0_BASE_DEF = 21'h080000;
  localparam logic [20:0] DSK1_BASE_DEF = 21'h100000;
  localparam logic [23:0] DSK_DS_WORDS  = 24'd409600;
  localparam logic [23:0] DSK_SS_WORDS  = 24'd204800;

endpackage

// File: rtl/dio_word_fifo.sv
// rtl/dio_word_fifo.sv - synchronous word FIFO with occupancy count
module dio_word_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 37
) (
  input  logic                       clk_sys,
  input  logic                       n_reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow
);
  localparam int             AW       = $clog2(DEPTH);
  localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]    CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0]  PTR_ONE  = AW'(1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  always_comb begin
    do_pop   = pop && (count_q != '0);
    // A simultaneous pop frees the slot the push needs.
    do_push  = push && ((count_q != FULL_CNT) || do_pop);
    overflow = push && !do_push;
    wr_ptr_d = do_push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop) count_d = count_q + CNT_ONE;
    else if (do_pop && !do_push) count_d = count_q - CNT_ONE;
  end

  always_ff @(posedge clk_sys) begin
    if (!n_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (do_push) mem[wr_ptr_q] <= din;
  end

  assign dout  = mem[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/dio_sdram_loader.sv
// rtl/dio_sdram_loader.sv - packs ioctl bytes into words and writes them to SDRAM in granted slots
// Optional running checksum of written words: define DIO_CHECKSUM_EN.
module dio_sdram_loader
  import dio_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter logic [20:0] ROM_BASE  = ROM_BASE_DEF,
  parameter logic [20:0] DSK0_BASE = DSK0_BASE_DEF,
  parameter logic [20:0] DSK1_BASE = DSK1_BASE_DEF
) (
  input  logic        clk_sys,
  input  logic        n_reset,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  input  logic        slot,
  output logic        dl_cycle,
  output logic [24:0] sdram_addr,
  output logic [15:0] sdram_din,
  output logic        sdram_we,
  input  logic [1:0]  disk_eject,
  output logic [1:0]  dsk_ds,
  output logic [1:0]  dsk_ss,
  output logic        rom_loaded
`ifdef DIO_CHECKSUM_EN
  ,
  output logic [15:0] checksum
`endif
);
  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] WAIT_CNT = (AW+1)'(DEPTH-1);

  function automatic logic [20:0] base_for(input logic [7:0] idx);
    if (idx == 8'd0) return ROM_BASE;
    if (idx == 8'd1) return DSK0_BASE;
    return DSK1_BASE;
  endfunction

  wr_state_t   state_q, state_d;
  fin_t        fin_q, fin_d;
  fifo_entry_t push_entry, head;
  logic [ENTRY_W-1:0] fifo_dout;
  logic [AW:0] count;
  logic        push, pop, fifo_ovf, busy, dl_fall, dl_rise, apply;
  logic        dl_prev_q, dl_prev_d, hi_pend_q, hi_pend_d, wait_q, wait_d;
  logic        we_q, we_d, rom_q, rom_d, ovf_q, ovf_d;
  logic [7:0]  hi_q, hi_d;
  logic [20:0] hi_waddr_q, hi_waddr_d;
  logic [24:0] addr_q, addr_d;
  logic [15:0] din_q, din_d;
  logic [1:0]  ds_q, ds_d, ss_q, ss_d;

  dio_word_fifo #(.DEPTH(DEPTH), .W(ENTRY_W)) u_fifo (
    .clk_sys  (clk_sys),
    .n_reset  (n_reset),
    .push     (push),
    .pop      (pop),
    .din      (push_entry),
    .dout     (fifo_dout),
    .count    (count),
    .overflow (fifo_ovf)
  );

  assign head = fifo_entry_t'(fifo_dout);

  always_comb begin
    dl_prev_d  = ioctl_download;
    dl_fall    = dl_prev_q && !ioctl_download;
    dl_rise    = !dl_prev_q && ioctl_download;
    hi_d       = hi_q;
    hi_pend_d  = hi_pend_q;
    hi_waddr_d = hi_waddr_q;
    push       = 1'b0;
    push_entry = '0;
    if (ioctl_wr && !ioctl_addr[0]) begin
      hi_d       = ioctl_dout;
      hi_pend_d  = 1'b1;
      hi_waddr_d = ioctl_addr[21:1];
    end else if (ioctl_wr) begin
      push            = 1'b1;
      hi_pend_d       = 1'b0;
      push_entry.addr = base_for(ioctl_index) + ioctl_addr[21:1];
      push_entry.data = {hi_q, ioctl_dout};
    end else if (dl_fall && hi_pend_q) begin
      // Odd-length image: pad the dangling high byte.
      push            = 1'b1;
      hi_pend_d       = 1'b0;
      push_entry.addr = base_for(ioctl_index) + hi_waddr_q;
      push_entry.data = {hi_q, 8'hFF};
    end
    ovf_d  = ovf_q | fifo_ovf;
    wait_d = (count >= WAIT_CNT);
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    din_d   = din_q;
    we_d    = we_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: if (count != '0) begin
        addr_d  = {4'b0001, head.addr};
        din_d   = head.data;
        state_d = ST_ARMED;
      end
      ST_ARMED: if (slot) begin
        we_d    = 1'b1;
        state_d = ST_WRITE;
      end
      ST_WRITE: if (!slot) begin
        we_d    = 1'b0;
        pop     = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    apply = fin_q.pend && (count == '0) && (state_q == ST_IDLE);
    fin_d = fin_q;
    if (apply) fin_d.pend = 1'b0;
    if (dl_fall) fin_d = '{pend: 1'b1, idx: ioctl_index, size: ioctl_addr[24:1]};
    ds_d  = ds_q;
    ss_d  = ss_q;
    rom_d = rom_q;
    if (apply) begin
      case (fin_q.idx)
        8'd0: rom_d = 1'b1;
        8'd1: begin
          ds_d[0] = (fin_q.size == DSK_DS_WORDS);
          ss_d[0] = (fin_q.size == DSK_SS_WORDS);
        end
        8'd2: begin
          ds_d[1] = (fin_q.size == DSK_DS_WORDS);
          ss_d[1] = (fin_q.size == DSK_SS_WORDS);
        end
        default: ;
      endcase
    end
    // Eject is applied last so it wins over a same-cycle result.
    ds_d = ds_d & ~disk_eject;
    ss_d = ss_d & ~disk_eject;
  end

  always_ff @(posedge clk_sys) begin
    if (!n_reset) begin
      state_q    <= ST_IDLE;
      fin_q      <= '0;
      dl_prev_q  <= 1'b0;
      hi_q       <= '0;
      hi_pend_q  <= 1'b0;
      hi_waddr_q <= '0;
      wait_q     <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      din_q      <= '0;
      ds_q       <= '0;
      ss_q       <= '0;
      rom_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fin_q      <= fin_d;
      dl_prev_q  <= dl_prev_d;
      hi_q       <= hi_d;
      hi_pend_q  <= hi_pend_d;
      hi_waddr_q <= hi_waddr_d;
      wait_q     <= wait_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      ds_q       <= ds_d;
      ss_q       <= ss_d;
      rom_q      <= rom_d;
      ovf_q      <= ovf_d;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (n_reset) assert (!ovf_q);
  end

`ifdef DIO_CHECKSUM_EN
  logic [15:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (pop) csum_d = csum_q + din_q;
    if (dl_rise) csum_d = '0;
  end

  always_ff @(posedge clk_sys) begin
    if (!n_reset) csum_q <= '0;
    else csum_q <= csum_d;
  end

  assign checksum = csum_q;
`endif

  assign busy       = ioctl_download || (count != '0) || (state_q != ST_IDLE);
  assign dl_cycle   = n_reset && busy && slot;
  assign ioctl_wait = wait_q;
  assign sdram_we   = we_q;
  assign sdram_addr = addr_q;
  assign sdram_din  = din_q;
  assign dsk_ds     = ds_q;
  assign dsk_ss     = ss_q;
  assign rom_loaded = rom_q;

endmodule

// File: tb/tb_dio_sdram_loader.sv
// tb/tb_dio_sdram_loader.sv - self-checking bench for dio_sdram_loader
module tb_dio_sdram_loader;

  logic        clk_sys = 1'b0;
  logic        n_reset;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;
  logic        slot;
  logic        dl_cycle;
  logic [24:0] sdram_addr;
  logic [15:0] sdram_din;
  logic        sdram_we;
  logic [1:0]  disk_eject;
  logic [1:0]  dsk_ds;
  logic [1:0]  dsk_ss;
  logic        rom_loaded;
`ifdef DIO_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  always #5 clk_sys = ~clk_sys;

  dio_sdram_loader dut (
`ifdef DIO_CHECKSUM_EN
    .checksum       (checksum),
`endif
    .clk_sys        (clk_sys),
    .n_reset        (n_reset),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wait     (ioctl_wait),
    .slot           (slot),
    .dl_cycle       (dl_cycle),
    .sdram_addr     (sdram_addr),
    .sdram_din      (sdram_din),
    .sdram_we       (sdram_we),
    .disk_eject     (disk_eject),
    .dsk_ds         (dsk_ds),
    .dsk_ss         (dsk_ss),
    .rom_loaded     (rom_loaded)
  );

  typedef struct { logic [24:0] addr; logic [15:0] data; } wr_t;
  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [7:0]  idx;
    int          nbytes;
    logic [24:0] fin_addr;
    bit          fixed;
    logic [1:0]  exp_ds;
    logic [1:0]  exp_ss;
    logic        exp_rom;
  } vec_t;

  int   checks = 0;
  int   fails  = 0;
  int   writes_seen = 0;
  wr_t  exp_q[$];
  wr_t  log_q[$];
  wr_t  mon_e;
  logic we_prev = 1'b0;
  bit   slot_en = 0;
  int   slot_cnt = 0;
  int   slot_per = 8;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_bool(input string name, input bit ok);
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: condition false, expected true", name);
    end
  endtask

  // Slot generator: short high pulses at a randomly varying period.
  initial begin
    slot = 1'b0;
    forever begin
      @(negedge clk_sys);
      if (slot_en) begin
        slot_cnt++;
        if (slot_cnt >= slot_per) begin
          slot_cnt = 0;
          slot_per = $urandom_range(4, 10);
        end
        slot = (slot_cnt < 2);
      end else begin
        slot_cnt = 0;
        slot = 1'b0;
      end
    end
  end

  // Each rising sdram_we is one write; it must match the next expected word.
  always @(negedge clk_sys) begin
    if (sdram_we && !we_prev) begin
      writes_seen++;
      if (exp_q.size() == 0) begin
        chk_bool("unexpected_write", 1'b0);
      end else begin
        mon_e = exp_q.pop_front();
        log_q.push_back('{addr: sdram_addr, data: sdram_din});
        chk("wr_addr", 32'(sdram_addr), 32'(mon_e.addr));
        chk("wr_data", 32'(sdram_din), 32'(mon_e.data));
      end
    end
    we_prev = sdram_we;
  end

  // Reference: byte i of a download lands in word i/2 at base(index), odd tail padded with FF.
  task automatic model_words(input logic [7:0] idx, input bq_t b);
    int base;
    int n;
    base = (idx == 0) ? 0 : (idx == 1) ? 'h80000 : 'h100000;
    n = b.size();
    for (int w = 0; w < (n + 1) / 2; w++) begin
      wr_t e;
      e.addr = 25'h0200000 + 25'((base + w) % 2097152);
      if (2 * w + 1 < n) e.data = {b[2*w], b[2*w+1]};
      else e.data = {b[2*w], 8'hFF};
      exp_q.push_back(e);
    end
  endtask

  task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
    int t = 0;
    while (ioctl_wait && t < 500) begin
      @(negedge clk_sys);
      t++;
    end
    chk_bool("wait_timeout", t < 500);
    ioctl_wr   = 1'b1;
    ioctl_addr = a;
    ioctl_dout = d;
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
  endtask

  task automatic begin_dl(input logic [7:0] idx);
    ioctl_index    = idx;
    ioctl_download = 1'b1;
    @(negedge clk_sys);
  endtask

  task automatic end_dl(input logic [24:0] fin_addr);
    ioctl_addr     = fin_addr;
    ioctl_download = 1'b0;
    @(negedge clk_sys);
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      @(negedge clk_sys);
      t++;
    end
    chk_bool("drain_timeout", exp_q.size() == 0);
    repeat (20) @(negedge clk_sys);
  endtask

  task automatic run_dl(input logic [7:0] idx, input bq_t b, input logic [24:0] fin_addr);
    model_words(idx, b);
    begin_dl(idx);
    for (int i = 0; i < b.size(); i++) begin
      send_byte(25'(i), b[i]);
      repeat ($urandom_range(0, 2)) @(negedge clk_sys);
    end
    end_dl(fin_addr);
    drain();
  endtask

  vec_t vecs[5];
  bq_t  bytes;
  int   seen0;
  int   t;

  initial begin
    vecs[0] = '{8'd0, 8, 25'd8,      1'b1, 2'b00, 2'b00, 1'b1};
    vecs[1] = '{8'd1, 6, 25'd819200, 1'b0, 2'b01, 2'b00, 1'b1};
    vecs[2] = '{8'd2, 5, 25'd409600, 1'b0, 2'b01, 2'b10, 1'b1};
    vecs[3] = '{8'd3, 4, 25'd409600, 1'b0, 2'b01, 2'b10, 1'b1};
    vecs[4] = '{8'd1, 3, 25'd409600, 1'b0, 2'b00, 2'b11, 1'b1};

    n_reset = 1'b0; ioctl_download = 1'b0; ioctl_index = '0; ioctl_wr = 1'b0;
    ioctl_addr = '0; ioctl_dout = '0; disk_eject = '0;
    repeat (3) @(negedge clk_sys);
    chk("rst_wait", 32'(ioctl_wait), 0);
    chk("rst_dl_cycle", 32'(dl_cycle), 0);
    chk("rst_we", 32'(sdram_we), 0);
    chk("rst_addr", 32'(sdram_addr), 0);
    chk("rst_din", 32'(sdram_din), 0);
    chk("rst_ds", 32'(dsk_ds), 0);
    chk("rst_ss", 32'(dsk_ss), 0);
    chk("rst_rom", 32'(rom_loaded), 0);
    n_reset = 1'b1;
    @(negedge clk_sys);

    slot_en = 1;
    for (int v = 0; v < 5; v++) begin
      bytes = {};
      for (int i = 0; i < vecs[v].nbytes; i++)
        bytes.push_back(vecs[v].fixed ? 8'(i) : 8'($urandom_range(0, 255)));
      log_q = {};
      run_dl(vecs[v].idx, bytes, vecs[v].fin_addr);
      chk($sformatf("vec%0d_ds", v), 32'(dsk_ds), 32'(vecs[v].exp_ds));
      chk($sformatf("vec%0d_ss", v), 32'(dsk_ss), 32'(vecs[v].exp_ss));
      chk($sformatf("vec%0d_rom", v), 32'(rom_loaded), 32'(vecs[v].exp_rom));
      if (v == 0) begin
        chk("rom_nwrites", 32'(log_q.size()), 4);
        if (log_q.size() == 4) begin
          chk("rom_first_addr", 32'(log_q[0].addr), 32'h0200000);
          chk("rom_first_data", 32'(log_q[0].data), 32'h0001);
          chk("rom_last_addr", 32'(log_q[3].addr), 32'h0200003);
          chk("rom_last_data", 32'(log_q[3].data), 32'h0607);
        end
      end
    end

    disk_eject = 2'b10;
    @(negedge clk_sys);
    disk_eject = 2'b00;
    @(negedge clk_sys);
    chk("eject1_ss", 32'(dsk_ss), 32'b01);
    chk("eject1_ds", 32'(dsk_ds), 32'b00);
    disk_eject = 2'b01;
    @(negedge clk_sys);
    disk_eject = 2'b00;
    @(negedge clk_sys);
    chk("eject0_ss", 32'(dsk_ss), 32'b00);

    // Odd length: trailing byte padded with FF.
    log_q = {};
    bytes = {8'hAA, 8'hBB, 8'hCC};
    run_dl(8'd1, bytes, 25'd3);
    chk("odd_nwrites", 32'(log_q.size()), 2);
    if (log_q.size() == 2) begin
      chk("odd_w0", 32'(log_q[0].data), 32'hAABB);
      chk("odd_w1", 32'(log_q[1].data), 32'hCCFF);
      chk("odd_a1", 32'(log_q[1].addr), 32'h0280001);
    end
    chk("odd_ds", 32'(dsk_ds), 0);

    // Backpressure with no slots, then drain.
    slot_en = 0;
    @(negedge clk_sys);
    bytes = {};
    for (int i = 0; i < 10; i++) bytes.push_back(8'($urandom_range(0, 255)));
    model_words(8'd0, bytes);
    seen0 = writes_seen;
    begin_dl(8'd0);
    for (int i = 0; i < 6; i++) send_byte(25'(i), bytes[i]);
    repeat (3) @(negedge clk_sys);
    chk("bp_wait_high", 32'(ioctl_wait), 1);
    chk("bp_no_we", 32'(sdram_we), 0);
    chk("bp_no_writes", 32'(writes_seen - seen0), 0);
    slot_en = 1;
    t = 0;
    while (ioctl_wait && t < 200) begin
      @(negedge clk_sys);
      t++;
    end
    chk_bool("bp_wait_drop_timeout", t < 200);
    chk("bp_one_write_before_drop", 32'(writes_seen - seen0), 1);
    for (int i = 6; i < 10; i++) send_byte(25'(i), bytes[i]);
    end_dl(25'd10);
    drain();
    chk("bp_wait_low", 32'(ioctl_wait), 0);
    chk("bp_total_writes", 32'(writes_seen - seen0), 5);

    // Reset while a word is armed but never granted a slot.
    slot_en = 0;
    @(negedge clk_sys);
    begin_dl(8'd1);
    send_byte(25'd0, 8'h12);
    send_byte(25'd1, 8'h34);
    repeat (3) @(negedge clk_sys);
    seen0 = writes_seen;
    n_reset = 1'b0;
    ioctl_download = 1'b0;
    @(negedge clk_sys);
    chk("rst_armed_we", 32'(sdram_we), 0);
    @(negedge clk_sys);
    n_reset = 1'b1;
    chk("rst_armed_rom", 32'(rom_loaded), 0);
    chk("rst_armed_ds", 32'(dsk_ds), 0);
    chk("rst_armed_ss", 32'(dsk_ss), 0);
    chk("rst_armed_wait", 32'(ioctl_wait), 0);
    slot_en = 1;
    t = 0;
    while (!slot && t < 50) begin
      @(negedge clk_sys);
      t++;
    end
    chk_bool("rst_slot_timeout", t < 50);
    chk("rst_dl_cycle_idle", 32'(dl_cycle), 0);
    repeat (40) @(negedge clk_sys);
    chk("rst_no_write", 32'(writes_seen - seen0), 0);

`ifdef DIO_CHECKSUM_EN
    bytes = {8'h00, 8'h01, 8'h02, 8'h03};
    run_dl(8'd0, bytes, 25'd4);
    chk("checksum", 32'(checksum), 32'h0204);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
